// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O port responder: PORT_OUT, synchronized PORT_IN, W1C STATUS, optional down-counting TIMER.
// Latency: zero wait states; reads are combinational from registered state, writes commit at the clk edge.
// Backpressure: none; every access completes in the cycle it is presented (no handshake).
//
// Ports: clk/reset (async active-high), Address/WriteData/MemWrite/MemRead/ReadData/Hit processor side,
//        PortIn (async pins), PortOut (output register), Irq (OR of STATUS[1:0]).
// Register window at BASE_ADDR: 0x0 PORT_OUT (RW), 0x4 PORT_IN (RO), 0x8 STATUS (W1C), 0xC TIMER (RW).
// Build option: define MMIO_TIMER_EN to include the TIMER register and STATUS[1] (TIMER_DONE);
//               without it offset 0xC still decodes but reads 0 and ignores writes.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        Irq
);

  localparam logic [1:0] SEL_PORT_OUT = 2'd0;
  localparam logic [1:0] SEL_PORT_IN  = 2'd1;
  localparam logic [1:0] SEL_STATUS   = 2'd2;
  localparam logic [1:0] SEL_TIMER    = 2'd3;

  logic [1:0]  regSel;
  logic        wrEn;
  logic        wrPortOut;
  logic        wrStatus;
  logic [31:0] portOutReg;
  logic [7:0]  s1;
  logic [7:0]  s2;
  logic [7:0]  prev;
  logic [1:0]  status;
  logic [1:0]  statusNext;
  logic        inChangedSet;
  logic        timerDoneSet;
  logic [31:0] timerCount;

  // Word-aligned addresses inside the 16-byte window only.
  assign Hit    = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign regSel = Address[3:2];

  assign wrEn      = MemWrite & Hit;
  assign wrPortOut = wrEn && (regSel == SEL_PORT_OUT);
  assign wrStatus  = wrEn && (regSel == SEL_STATUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      portOutReg <= '0;
    end else if (wrPortOut) begin
      portOutReg <= WriteData;
    end
  end

  assign PortOut = portOutReg;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= PortIn;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign inChangedSet = (s2 != prev);

`ifdef MMIO_TIMER_EN
  logic wrTimer;

  assign wrTimer = wrEn && (regSel == SEL_TIMER);

  // A write always wins over the decrement, so a write of 0 stops the count silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timerCount <= '0;
    end else if (wrTimer) begin
      timerCount <= WriteData;
    end else if (timerCount != 32'd0) begin
      timerCount <= timerCount - 32'd1;
    end
  end

  // Only a decrement from 1 reaches zero "naturally"; a write never flags completion.
  assign timerDoneSet = !wrTimer && (timerCount == 32'd1);
`else
  assign timerCount   = '0;
  assign timerDoneSet = 1'b0;
`endif

  // Set events override a same-edge write-1-to-clear of the same bit.
  always_comb begin
    statusNext = status;
    if (wrStatus) begin
      statusNext = status & ~WriteData[1:0];
    end
    statusNext = statusNext | {timerDoneSet, inChangedSet};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= '0;
    end else begin
      status <= statusNext;
    end
  end

  assign Irq = |status;

  // Reads return pre-write contents, so a simultaneous read+write sees the old value.
  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      case (regSel)
        SEL_PORT_OUT: ReadData = portOutReg;
        SEL_PORT_IN:  ReadData = {24'b0, s2};
        SEL_STATUS:   ReadData = {30'b0, status};
        SEL_TIMER:    ReadData = timerCount;
        default:      ReadData = '0;
      endcase
    end
  end

endmodule

// File: doc/mmio_port_responder.md
MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, byte address of the 16-byte register window (bits [3:0] zero).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Address  input  32  byte address from the processor data path.
REQ-005 SHALL have port WriteData  input  32  store data.
REQ-006 SHALL have port MemWrite  input  1  store strobe, sampled on the clk rising edge.
REQ-007 SHALL have port MemRead  input  1  load strobe.
REQ-008 SHALL have port ReadData  output  32  load data, combinational from registered state.
REQ-009 SHALL have port Hit  output  1  high when Address decodes to a valid register.
REQ-010 SHALL have port PortIn  input  8  asynchronous external input pins.
REQ-011 SHALL have port PortOut  output  32  external output register.
REQ-012 SHALL have port Irq  output  1  OR of STATUS bits [1:0], registered state only.

Function
REQ-013 SHALL decode offset 0x0 PORT_OUT (RW), 0x4 PORT_IN (RO), 0x8 STATUS (R / write-1-to-clear), 0xC TIMER (RW); Hit=1 only when Address[31:4]==BASE_ADDR[31:4] and Address[1:0]==0.
REQ-014 SHALL, when Hit=0 or MemRead=0, drive ReadData=0; writes with Hit=0 SHALL have no effect.
REQ-015 SHALL perform writes at the clk edge where MemWrite=1 and Hit=1; zero wait states, no handshake.
REQ-016 SHALL, with MemRead and MemWrite both high, return pre-write register contents on ReadData and perform the write at the edge.
REQ-017 SHALL drive PortOut from the PORT_OUT register; write visible on PortOut the cycle after the edge.
REQ-018 SHALL pass PortIn through a two-flop synchronizer (s1, s2) plus history flop prev; PORT_IN read returns {24'b0, s2}, i.e., a pin change is readable after the 2nd edge.
REQ-019 SHALL set STATUS[0] (IN_CHANGED) at the edge where s2!=prev (3rd edge after pin change); sticky until cleared.
REQ-020 SHALL clear STATUS bits written with 1 at offset 0x8; writes of 0 SHALL leave bits unchanged; STATUS[31:2] read 0.
REQ-021 SHALL give set priority over clear when a set event and a W1C write to the same bit occur at the same edge.
REQ-022 SHALL load TIMER from WriteData on write to 0xC; otherwise decrement by 1 each edge while nonzero; hold at 0.
REQ-023 SHALL set STATUS[1] (TIMER_DONE) at the edge where TIMER transitions 1->0 by decrement only; a write of 0 SHALL stop the timer without setting TIMER_DONE.
REQ-024 SHALL let a write to TIMER while counting reload it (write wins over decrement); reads of 0xC return current count.

Reset
REQ-025 SHALL, on reset assertion, immediately set PORT_OUT=0, s1=s2=prev=0, STATUS=0, TIMER=0; hence PortOut=0, Irq=0.
REQ-026 SHALL abort any count in progress on reset without setting TIMER_DONE; after release, first edge SHALL behave as normal operation.
REQ-027 SHALL not flag IN_CHANGED for the first synchronizer fill after reset if PortIn=0; a nonzero PortIn at release SHALL set IN_CHANGED at the 3rd edge.

Configuration
REQ-028 SHALL compile the timer (TIMER register, STATUS[1]) only when macro MMIO_TIMER_EN is defined.
REQ-029 SHALL, without MMIO_TIMER_EN, keep offset 0xC decoded (Hit=1), read 0, ignore writes, and hold STATUS[1]=0.

Verification
REQ-030 SHALL cover: store 32'hDEAD_BEEF to BASE_ADDR -> PortOut=32'hDEAD_BEEF next cycle; load BASE_ADDR returns same.
REQ-031 SHALL cover: PortIn 8'h00->8'hA5 -> load BASE_ADDR+4 returns 32'h0000_00A5 after 2 edges; STATUS=32'h1 and Irq=1 after 3rd edge; store 32'h1 to +8 -> STATUS=0, Irq=0.
REQ-032 SHALL cover (MMIO_TIMER_EN): store 3 to +0xC -> reads 2,1,0 on following cycles; STATUS[1]=1 at the edge reaching 0; store 0 mid-count -> STATUS[1] stays 0.
REQ-033 SHALL cover: W1C of STATUS[0] on same edge as new pin change -> STATUS[0] remains 1.
REQ-034 SHALL cover: load BASE_ADDR+2 and BASE_ADDR+16 -> Hit=0, ReadData=0; store there -> no register change.
REQ-035 SHALL cover: reset asserted mid-count with PORT_OUT=32'h1234 -> PortOut=0, TIMER=0, STATUS=0 immediately, without waiting for clk.
